// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and PC constants for the PC sequencer.
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, WAIT = 2'd2, HALTED = 2'd3} state_e;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch/redirect bus between branch logic, imem, PC register and the sequencer.
interface pc_sequencer_if;
  logic [31:0] instr_addr;
  logic instr_ready;
  logic branch_taken;
  logic [31:0] branch_target;
  logic jump;
  logic [31:0] jump_target;
  logic halt;
  logic [31:0] next_pc;
  logic fetch_valid;
  logic halted;
  logic trap;
  logic [31:0] trap_epc;
  modport master (
    output instr_addr, instr_ready, branch_taken, branch_target, jump, jump_target, halt,
    input next_pc, fetch_valid, halted, trap, trap_epc
  );
  modport slave (
    input instr_addr, instr_ready, branch_taken, branch_target, jump, jump_target, halt,
    output next_pc, fetch_valid, halted, trap, trap_epc
  );
endinterface

// File: rtl/pc_redirect_mux.sv
// pc_redirect_mux: priority select jump > branch > pending > +4, with misaligned-target trap
// substitution when PC_SEQ_TRAP_EN is defined.
module pc_redirect_mux
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] instr_addr_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        pend_vld_i,
  input  logic [31:0] pend_tgt_i,
  output logic [31:0] pc_o,
  output logic [31:0] raw_tgt_o,
  output logic        redirect_o,
  output logic        misaligned_o
);
  assign raw_tgt_o  = jump_i ? jump_target_i : branch_taken_i ? branch_target_i : pend_tgt_i;
  assign redirect_o = jump_i | branch_taken_i | pend_vld_i;
`ifdef PC_SEQ_TRAP_EN
  assign misaligned_o = redirect_o && ((raw_tgt_o[1:0] & ALIGN_MASK) != 2'b00);
  assign pc_o = redirect_o ? (misaligned_o ? TRAP_VECTOR : raw_tgt_o) : instr_addr_i + PC_STEP;
`else
  logic unused_trap_vector;
  assign unused_trap_vector = ^TRAP_VECTOR;
  assign misaligned_o = 1'b0;
  assign pc_o = redirect_o ? raw_tgt_o : instr_addr_i + PC_STEP;
`endif
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next_pc arbitration FSM (BOOT/RUN/WAIT/HALTED) with stall-parked redirects.
// Optional misaligned-target trapping is enabled by defining PC_SEQ_TRAP_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  localparam int CW = BOOT_CYCLES > 1 ? $clog2(BOOT_CYCLES) : 1;
  state_e state_q, state_d;
  logic [CW-1:0] boot_cnt_q, boot_cnt_d;
  logic pend_vld_q, pend_vld_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic trap_q, trap_d;
  logic [31:0] trap_epc_q, trap_epc_d;
  logic [31:0] mux_pc, raw_tgt;
  logic redirect, misaligned;
  pc_redirect_mux #(.TRAP_VECTOR(TRAP_VECTOR)) u_mux (
    .instr_addr_i(bus.instr_addr),
    .jump_i(bus.jump),
    .jump_target_i(bus.jump_target),
    .branch_taken_i(bus.branch_taken),
    .branch_target_i(bus.branch_target),
    .pend_vld_i(pend_vld_q),
    .pend_tgt_i(pend_tgt_q),
    .pc_o(mux_pc),
    .raw_tgt_o(raw_tgt),
    .redirect_o(redirect),
    .misaligned_o(misaligned)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      trap_q     <= 1'b0;
      trap_epc_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      trap_q     <= trap_d;
      trap_epc_q <= trap_epc_d;
    end
  end
  always_comb begin
    state_d         = state_q;
    boot_cnt_d      = boot_cnt_q;
    pend_vld_d      = pend_vld_q;
    pend_tgt_d      = pend_tgt_q;
    trap_d          = 1'b0;
    trap_epc_d      = trap_epc_q;
    bus.next_pc     = bus.instr_addr;
    bus.fetch_valid = 1'b0;
    bus.halted      = 1'b0;
    case (state_q)
      BOOT: begin
        bus.next_pc = RESET_VECTOR;
        boot_cnt_d  = boot_cnt_q + 1'b1;
        state_d     = (boot_cnt_q == CW'(BOOT_CYCLES - 1)) ? RUN : BOOT;
      end
      RUN, WAIT: begin
        bus.fetch_valid = bus.instr_ready & ~bus.halt;
        if (bus.halt) begin
          state_d    = HALTED;
          pend_vld_d = 1'b0;
        end else if (bus.instr_ready) begin
          // Any applied redirect supersedes a parked one, so the park is always consumed.
          bus.next_pc = mux_pc;
          pend_vld_d  = 1'b0;
          trap_d      = misaligned;
          trap_epc_d  = misaligned ? raw_tgt : trap_epc_q;
          state_d     = RUN;
        end else begin
          state_d    = WAIT;
          pend_vld_d = pend_vld_q | bus.jump | bus.branch_taken;
          pend_tgt_d = bus.jump ? bus.jump_target : bus.branch_taken ? bus.branch_target : pend_tgt_q;
        end
      end
      default: bus.halted = 1'b1;
    endcase
  end
  assign bus.trap     = trap_q;
  assign bus.trap_epc = trap_epc_q;
endmodule
